// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator with a small prefetch FIFO
// feeding the decode stage. A redirect flushes the queue and reloads the
// fetch PC. All state is cleared asynchronously while reset is low.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined and the queue is empty, the word returned by instruction
//   memory is presented to decode in the same cycle. Without the macro the
//   fetch-to-decode latency is one cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_adrs,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall_D,
    output logic        valid_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [3:0]  count
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    logic [31:0]   fpc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic stored_valid;
    logic pop;
    logic push;
    logic byp;
    logic bypass_take;

    assign imem_adrs = fpc;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Gated by reset so nothing is offered to decode while held in reset.
    assign byp = reset && !redirect && (count == 4'd0);
`else
    assign byp = 1'b0;
`endif

    // Queue handshake decode and decode-stage output selection.
    always_comb begin
        stored_valid = !redirect && (count != 4'd0);
        pop          = stored_valid && !stall_D;
        bypass_take  = byp && !stall_D;
        // A full queue may still accept a word when the head leaves this cycle.
        push         = !redirect && !bypass_take && ((count < DEPTH_C) || pop);
        valid_D      = stored_valid || byp;
        instr_D      = NOP;
        pc_D         = 32'h0;
        if (stored_valid) begin
            instr_D = instr_mem[head];
            pc_D    = pc_mem[head];
        end else if (byp) begin
            instr_D = imem_rd;
            pc_D    = fpc;
        end
    end

    // Fetch PC, pointers and occupancy; redirect wins over everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc   <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= 4'd0;
        end else if (redirect) begin
            fpc   <= redirect_pc & 32'hFFFF_FFFC;
            head  <= '0;
            tail  <= '0;
            count <= 4'd0;
        end else begin
            if (push || bypass_take) begin
                fpc <= fpc + 32'd4;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + {3'd0, push} - {3'd0, pop};
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= fpc;
            instr_mem[tail] <= imem_rd;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH=4, RESET_PC=0).
// The driver pushes the expected fetch-address stream; a negedge monitor pops
// and compares every word that decode actually consumes.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_adrs;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic        valid_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;
    int seen  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_adrs(imem_adrs), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall_D(stall_D),
        .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D), .count(count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word is a simple function of its address.
    assign imem_rd = imem_adrs ^ KEY;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Monitor: every consumed word must be the next expected fetch address.
    always @(negedge clk) begin
        if (valid_D === 1'b1 && stall_D === 1'b0) begin
            seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h expected none", pc_D);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_pc", pc_D, mon_e);
                check("pop_instr", instr_D, mon_e ^ KEY);
            end
        end else if (valid_D === 1'b0) begin
            check("idle_instr", instr_D, NOP);
            check("idle_pc", pc_D, 32'h0);
        end
    end

    // Stimulus: directed scenarios.
    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall_D = 1'b0;

        // Reset state, then free-running fetch.
        cyc();
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_valid", {31'd0, valid_D}, 32'd0);
        check("rst_instr", instr_D, NOP);
        check("rst_pc", pc_D, 32'h0);
        check("rst_adrs", imem_adrs, 32'h0);
        load_exp(32'h0, 12);
        seen  = 0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("a_count", {28'd0, count}, BYP ? 32'd0 : 32'd1);
        end
        check("a_seen", 32'(seen), BYP ? 32'd6 : 32'd5);

        // Stall from reset: fill to DEPTH, hold, then drain in order.
        reset = 1'b0; stall_D = 1'b1;
        exp_q.delete();
        load_exp(32'h0, 12);
        seen = 0;
        cyc();
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("b_fill_count", {28'd0, count}, (i < 4) ? 32'(i) : 32'd4);
        end
        check("b_adrs", imem_adrs, 32'h10);
        check("b_head_pc", pc_D, 32'h0);
        stall_D = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("b_stream_count", {28'd0, count}, 32'd4);
        end
        check("b_seen", 32'(seen), 32'd5);

        // Redirect with a full queue, unaligned target.
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        #1;
        check("c_valid_forced", {31'd0, valid_D}, 32'd0);
        cyc();
        redirect = 1'b0;
        exp_q.delete();
        load_exp(32'h200, 8);
        seen = 0;
        #1;
        check("c_count", {28'd0, count}, 32'd0);
        check("c_adrs", imem_adrs, 32'h200);
        check("c_valid", {31'd0, valid_D}, BYP ? 32'd1 : 32'd0);
        for (int i = 0; i < 3; i++) cyc();
        check("c_seen", 32'(seen), BYP ? 32'd3 : 32'd2);

        // Redirect together with stall at count=3.
        redirect = 1'b1; redirect_pc = 32'h100; stall_D = 1'b1;
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        #1;
        check("d_count3", {28'd0, count}, 32'd3);
        redirect = 1'b1; redirect_pc = 32'h300;
        #1;
        check("d_valid_forced", {31'd0, valid_D}, 32'd0);
        cyc();
        redirect = 1'b0; stall_D = 1'b0;
        exp_q.delete();
        load_exp(32'h300, 8);
        seen = 0;
        #1;
        check("d_count", {28'd0, count}, 32'd0);
        check("d_adrs", imem_adrs, 32'h300);
        for (int i = 0; i < 3; i++) cyc();
        check("d_seen", 32'(seen), BYP ? 32'd3 : 32'd2);

        // Fetch PC wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect = 1'b0;
        exp_q.delete();
        load_exp(32'hFFFF_FFF8, 5);
        seen = 0;
        #1;
        check("e_adrs_start", imem_adrs, 32'hFFFF_FFF8);
        cyc();
        cyc();
        check("e_adrs_wrap", imem_adrs, 32'h0);
        cyc();
        cyc();
        check("e_seen", 32'(seen), BYP ? 32'd4 : 32'd3);

        // Asynchronous reset mid-stream at count=2.
        redirect = 1'b1; redirect_pc = 32'h40; stall_D = 1'b1;
        cyc();
        redirect = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        #1;
        check("f_count2", {28'd0, count}, 32'd2);
        check("f_valid", {31'd0, valid_D}, 32'd1);
        check("f_pc", pc_D, 32'h40);
        reset = 1'b0;
        #1;
        check("f_rst_valid", {31'd0, valid_D}, 32'd0);
        check("f_rst_instr", instr_D, NOP);
        check("f_rst_pc", pc_D, 32'h0);
        check("f_rst_count", {28'd0, count}, 32'd0);
        check("f_rst_adrs", imem_adrs, 32'h0);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL expose the following parameters:
  DEPTH, 4, queue entries (power of two, 2..8)
  RESET_PC, 32'h0000_0000, fetch address after reset
REQ-002 The block SHALL expose the following ports:
  clk  input  1  single clock, all state on rising edge
  reset  input  1  asynchronous, active-low reset
  imem_adrs  output  32  fetch address to instruction memory
  imem_rd  input  32  instruction word, combinational from imem_adrs
  redirect  input  1  branch/jump taken, flush and refetch
  redirect_pc  input  32  new fetch address when redirect=1
  stall_D  input  1  decode stage cannot accept this cycle
  valid_D  output  1  instr_D/pc_D hold a valid instruction
  instr_D  output  32  instruction presented to decode
  pc_D  output  32  address of instr_D
  count  output  4  current queue occupancy

Function
REQ-003 The block SHALL hold a fetch PC register (fpc) and drive imem_adrs = fpc combinationally.
REQ-004 The block SHALL store {fpc, imem_rd} at the tail and advance fpc by 4 in the same cycle when push is allowed: count<DEPTH, or count==DEPTH with a pop in the same cycle, and redirect=0.
REQ-005 The block SHALL drive valid_D=1 whenever count!=0 and redirect=0, with instr_D/pc_D taken from the head entry.
REQ-006 A pop SHALL occur exactly when valid_D=1 and stall_D=0; the head pointer then advances by one.
REQ-007 When a push and a pop occur in the same cycle, count SHALL be unchanged, including at count==DEPTH and count==1.
REQ-008 Head and tail pointers SHALL wrap modulo DEPTH; fpc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-009 When valid_D=0, instr_D SHALL equal 32'h0000_0013 (NOP) and pc_D SHALL equal 32'h0.
REQ-010 On redirect=1, the block SHALL behave as follows in the same edge:
  - count, head and tail return to 0
  - fpc loads {redirect_pc[31:2], 2'b00}
  - no push and no pop occur
  - valid_D is forced to 0 in that cycle
REQ-011 In the cycle after a redirect, imem_adrs SHALL equal the aligned redirect_pc.
REQ-012 Without bypass, the minimum latency from an address appearing on imem_adrs to its word appearing with valid_D=1 SHALL be 1 cycle.
REQ-013 Redirect SHALL take priority over stall_D and over a full queue.

Reset
REQ-014 While reset=0, the block SHALL hold the following state, independent of clk:
  - fpc=RESET_PC, count=0, head=0, tail=0
  - valid_D=0, instr_D=32'h0000_0013, pc_D=0
REQ-015 Asserting reset mid-operation SHALL discard all entries immediately.
REQ-016 On the first rising edge after reset deasserts, the word at RESET_PC SHALL be pushed.

Configuration
REQ-017 With macro FETCH_QUEUE_BYPASS_EN defined, when count==0 and redirect=0 the block SHALL behave as follows:
  - drive valid_D=1, instr_D=imem_rd and pc_D=fpc combinationally
  - if stall_D=0, the word is consumed without entering the queue and fpc advances by 4
  - if stall_D=1, the word is pushed normally
REQ-018 Without FETCH_QUEUE_BYPASS_EN, valid_D SHALL be driven only from stored entries, giving the 1-cycle latency of REQ-012.

Verification
REQ-019 The bench SHALL cover at least the following directed scenarios:
  - Reset release, stall_D=0, imem returning address-derived words: pc_D=0,4,8,... on consecutive cycles; count stays 1 (0 with bypass).
  - stall_D=1 for 6 cycles after reset, DEPTH=4: count reaches 4 and holds; imem_adrs holds 0x10. Release stall_D: pc_D sequence is 0,4,8,C,10 with no gap or duplicate.
  - Full queue, redirect=1 with redirect_pc=0x203: next cycle count=0, valid_D=0, imem_adrs=0x200. First valid pc_D=0x200 one cycle later (same cycle with bypass).
  - redirect and stall_D asserted together at count=3: queue empties; nothing is popped; no stale entry ever reaches valid_D.
  - fpc=0xFFFF_FFF8 with stall_D=0: pushed addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - reset pulled low mid-stream at count=2: valid_D=0 and instr_D=0x13 immediately, without waiting for a clk edge.
